// File: rtl/l1_mem_pkg.sv
// Shared types and line-geometry derivations for the L1 line memory responder.
package l1_mem_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int OFFSET_BITS_DEF = 3;
  localparam int WORDSIZE_DEF    = 4;
  localparam int BLOCKSIZE       = 1 << OFFSET_BITS_DEF;
  localparam int WORDSPERLINE    = BLOCKSIZE / WORDSIZE_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2,
    TURN    = 2'd3
  } state_t;

  typedef logic [WORDSPERLINE-1:0][DATA_WIDTH_DEF-1:0] line_t;

  function automatic int words_per_line(input int offset_bits, input int wordsize);
    return (1 << offset_bits) / wordsize;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick; the search starts one past the last winner and
// the pointer only moves when a grant is actually taken.
module rr_arbiter #(
  parameter  int NUM_CORES = 2,
  localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 en,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_req
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        grant[cand_idx]  = 1'b1;
        grant_idx        = cand_idx;
      end
    end
  end

  assign any_req = found;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/l1_line_memory_responder.sv
// Memory-side responder for the L1 line interface: one grant at a time,
// fixed-latency line storage, snoop broadcast on every accepted writeback.
//
//  state   | meaning
//  IDLE    | waiting for any core's re/we
//  ACCESS  | grant held, latency countdown; storage touched when cnt reaches 0
//  RESPOND | one-cycle ready pulse (plus snoop strobe on writes)
//  TURN    | grant dropped for one cycle so the requester can release its strobe
module l1_line_memory_responder
  import l1_mem_pkg::*;
#(
  parameter  int NUM_CORES    = 2,
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDRESS_BITS = 20,
  parameter  int OFFSET_BITS  = 3,
  parameter  int WORDSIZE     = 4,
  parameter  int LINE_BITS    = 8,
  parameter  int MEM_LATENCY  = 4,
  localparam int WPL          = words_per_line(OFFSET_BITS, WORDSIZE)
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [NUM_CORES-1:0][ADDRESS_BITS-1:0]      cache2mem_addr,
  input  logic [NUM_CORES-1:0][WPL-1:0][DATA_WIDTH-1:0] cache2mem_data,
  input  logic [NUM_CORES-1:0]                        cache2mem_we,
  input  logic [NUM_CORES-1:0]                        cache2mem_re,
  output logic [WPL-1:0][DATA_WIDTH-1:0]              mem2cache_data,
  output logic [NUM_CORES-1:0]                        mem2cache_ready,
  output logic [NUM_CORES-1:0]                        granted,
  output logic [DATA_WIDTH-1:0]                       snoop_addr,
  output logic                                        snoop_we
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int DEPTH = 1 << LINE_BITS;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic                           op_write;
  logic [LINE_BITS-1:0]           line_idx;
  logic [WPL-1:0][DATA_WIDTH-1:0] wr_line;
  logic [WPL*DATA_WIDTH-1:0]      storage [DEPTH];

  logic [NUM_CORES-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 arb_en;
  logic                 do_access;

  // Only the line-index field of the address selects storage; the rest aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cache2mem_addr;

  assign arb_en    = (state == IDLE) || (state == TURN);
  assign do_access = (state == ACCESS) && (cnt == '0);

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (cache2mem_we | cache2mem_re),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      op_write        <= 1'b0;
      line_idx        <= '0;
      wr_line         <= '0;
      granted         <= '0;
      mem2cache_ready <= '0;
      mem2cache_data  <= '0;
      snoop_addr      <= '0;
      snoop_we        <= 1'b0;
    end else begin
      mem2cache_ready <= '0;
      snoop_we        <= 1'b0;
      case (state)
        // The TURN cycle itself shows no grant; a decision taken at its exit
        // edge becomes visible in the following cycle.
        IDLE, TURN: begin
          granted <= '0;
          if (arb_any) begin
            state    <= ACCESS;
            op_write <= cache2mem_we[arb_idx];
            line_idx <= cache2mem_addr[arb_idx][OFFSET_BITS +: LINE_BITS];
            wr_line  <= cache2mem_data[arb_idx];
            granted  <= arb_grant;
            cnt      <= CNT_INIT;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state           <= RESPOND;
            mem2cache_ready <= granted;
            if (op_write) begin
              snoop_we   <= 1'b1;
              snoop_addr <= DATA_WIDTH'({line_idx, {OFFSET_BITS{1'b0}}});
            end else begin
              mem2cache_data <= storage[line_idx];
            end
          end
        end
        RESPOND: begin
          state   <= TURN;
          granted <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_access && op_write) begin
      storage[line_idx] <= wr_line;
    end
  end

endmodule

// File: tb/tb_l1_line_memory_responder.sv
// Directed bench for the L1 line memory responder with a queue-based scoreboard.
module tb_l1_line_memory_responder;
  import l1_mem_pkg::*;

  localparam int MEM_LATENCY = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0][19:0]  addr;
  logic [1:0][63:0]  wdata;
  logic [1:0]        we, re;
  line_t             rdata;
  logic [1:0]        ready, granted;
  logic [31:0]       snoop_addr;
  logic              snoop_we;

  typedef struct {
    int          core;
    bit          is_w;
    logic [31:0] saddr;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [63:0] D1  = 64'hA5A5A5A5_12345678;
  localparam logic [63:0] D4  = 64'h0BADF00D_CAFE0004;
  localparam logic [63:0] D5  = 64'h55550000_DEAD0005;
  localparam logic [63:0] D3A = 64'h3333AAAA_00000301;
  localparam logic [63:0] D3B = 64'h3333BBBB_00000302;

  l1_line_memory_responder dut (
    .clock           (clock),
    .reset           (reset),
    .cache2mem_addr  (addr),
    .cache2mem_data  (wdata),
    .cache2mem_we    (we),
    .cache2mem_re    (re),
    .mem2cache_data  (rdata),
    .mem2cache_ready (ready),
    .granted         (granted),
    .snoop_addr      (snoop_addr),
    .snoop_we        (snoop_we)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clock) begin
    if (!reset) begin
      n_cmp++;
      if (snoop_we && ready == 2'b00) begin
        n_fail++;
        $display("FAIL snoop_outside_respond: snoop_we=1 with ready=%b, required snoop_we=0", ready);
      end
      if (ready != 2'b00) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: ready=%b with no pending request, required 00", ready);
        end else begin
          logic [1:0] oh;
          mon_e = q.pop_front();
          oh = '0;
          oh[mon_e.core] = 1'b1;
          check("ready_onehot", 64'(ready), 64'(oh));
          check("snoop_we", 64'(snoop_we), 64'(mon_e.is_w));
          if (mon_e.is_w) check("snoop_addr", 64'(snoop_addr), 64'(mon_e.saddr));
          check("fill_data", rdata, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input int c, input bit w, input bit r, input logic [19:0] a, input logic [63:0] d);
    we[c]    = w;
    re[c]    = r;
    addr[c]  = a;
    wdata[c] = d;
  endtask

  task automatic push(input int c, input bit w, input logic [31:0] sa, input logic [63:0] d);
    exp_t e;
    e.core  = c;
    e.is_w  = w;
    e.saddr = sa;
    e.data  = d;
    q.push_back(e);
  endtask

  task automatic wait_ready(input int c, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ready[c]) break;
    end
    if (!ready[c]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: core%0d saw no ready within 40 cycles, required a pulse", c);
    end
    we[c] = 1'b0;
    re[c] = 1'b0;
  endtask

  task automatic serve(input int c);
    int         cyc;
    logic [1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    @(negedge clock);
    check("grant", 64'(granted), 64'(oh));
    wait_ready(c, cyc);
    check("ready_latency", 64'(cyc), 64'(MEM_LATENCY));
    @(negedge clock);
    check("turn_grant", 64'(granted), 64'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_granted", 64'(granted), 64'h0);
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_data", rdata, 64'h0);
    check("rst_snoop_addr", 64'(snoop_addr), 64'h0);
    check("rst_snoop_we", 64'(snoop_we), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    we = '0; re = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Writeback, then a fill from the other core on the same line.
    drive(0, 1, 0, 20'h00040, D1); push(0, 1, 32'h40, 64'h0); serve(0);
    drive(1, 0, 1, 20'h00044, '0); push(1, 0, '0, D1);        serve(1);

    // re and we together are a write; fill data must not change.
    drive(0, 1, 1, 20'h00100, D4); push(0, 1, 32'h100, D1);   serve(0);
    drive(1, 0, 1, 20'h00100, '0); push(1, 0, '0, D4);        serve(1);

    // Upper address bits alias onto line 8.
    drive(0, 0, 1, 20'h10040, '0); push(0, 0, '0, D1);        serve(0);

    // Reset in the middle of a write's latency window.
    drive(0, 1, 0, 20'h00040, D5);
    @(negedge clock);
    check("abort_grant", 64'(granted), 64'h1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    drive(0, 0, 0, '0, '0);
    reset = 1'b0;

    // Simultaneous pair after reset: core0 first; its read shows the aborted write never landed.
    drive(0, 0, 1, 20'h00040, '0);
    drive(1, 1, 0, 20'h00080, D3A);
    push(0, 0, '0, D1);
    push(1, 1, 32'h80, D1);
    serve(0); serve(1);

    // Pointer now back at core0.
    drive(0, 1, 0, 20'h000C0, D3B);
    drive(1, 0, 1, 20'h00080, '0);
    push(0, 1, 32'hC0, D1);
    push(1, 0, '0, D3A);
    serve(0); serve(1);

    // Core0 alone moves the pointer to core1, which then wins the next tie.
    drive(0, 0, 1, 20'h000C0, '0); push(0, 0, '0, D3B); serve(0);
    drive(1, 0, 1, 20'h00080, '0);
    drive(0, 0, 1, 20'h00100, '0);
    push(1, 0, '0, D3A);
    push(0, 0, '0, D4);
    serve(1); serve(0);

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
